// File: rtl/decode_rf_fwd_stage.sv
// rtl/decode_rf_fwd_stage.sv - Y86 decode stage with register file, forwarding and D->E pipeline register
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   D_*                        fetched instruction fields entering decode
//   e_dstE/e_valE              execute-stage result being produced this cycle
//   M_dstM/m_valM, M_dstE/M_valE  memory-stage results
//   W_dstM/W_valM, W_dstE/W_valE  writeback results, also the register file write ports
//   E_bubble, E_stall          pipeline control for the E register
//   E_*                        registered execute-stage fields
//   srcA, srcB, ld_use         combinational outputs for the hazard unit
//   dbg_addr, dbg_data         raw register file read, no forwarding
module decode_rf_fwd_stage #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [3:0]        D_stat,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic              E_bubble,
    input  logic              E_stall,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [3:0]        E_stat,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [DATA_W-1:0] E_valC,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic              ld_use,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = RSP_ID[3:0];

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;

    logic [DATA_W-1:0] rf [NREG];
    logic [3:0]        dstE, dstM;
    logic [DATA_W-1:0] valA, valB;

    function automatic logic rf_valid(input logic [3:0] id);
        return (id != RNONE) && (32'(id) < NREG);
    endfunction

    // Register file read; unknown or out-of-range IDs read as zero.
    function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] id);
        if (rf_valid(id))
            return rf[id];
        return '0;
    endfunction

    // Newest in-flight producer wins; the register file is the last resort.
    function automatic logic [DATA_W-1:0] fwd(input logic [3:0] id);
        if (id == RNONE)        return '0;
        else if (id == e_dstE)  return e_valE;
        else if (id == M_dstM)  return m_valM;
        else if (id == M_dstE)  return M_valE;
        else if (id == W_dstM)  return W_valM;
        else if (id == W_dstE)  return W_valE;
        else                    return rf_read(id);
    endfunction

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (D_icode)
            I_RRMOV: begin srcA = D_rA; dstE = D_rB; end
            I_IRMOV: begin dstE = D_rB; end
            I_RMMOV: begin srcA = D_rA; srcB = D_rB; end
            I_MRMOV: begin srcB = D_rB; dstM = D_rA; end
            I_OPQ:   begin srcA = D_rA; srcB = D_rB; dstE = D_rB; end
            I_CALL:  begin srcB = RSP; dstE = RSP; end
            I_RET:   begin srcA = RSP; srcB = RSP; dstE = RSP; end
            I_PUSH:  begin srcA = D_rA; srcB = RSP; dstE = RSP; end
            I_POP:   begin srcA = RSP; srcB = RSP; dstE = RSP; dstM = D_rA; end
            default: ;
        endcase
    end

    // jXX and call carry the return/fall-through PC in valA instead of a register.
    always_comb begin
        valA = fwd(srcA);
        if (D_icode == I_JXX || D_icode == I_CALL)
            valA = D_valP;
        valB = fwd(srcB);
    end

    assign ld_use = (E_icode == I_MRMOV || E_icode == I_POP) && (E_dstM != RNONE)
                  && (E_dstM == srcA || E_dstM == srcB);

    assign dbg_data = rf_read(dbg_addr);

    // Port M is applied after port E so a shared destination keeps the loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            if (rf_valid(W_dstE))
                rf[W_dstE] <= W_valE;
            if (rf_valid(W_dstM))
                rf[W_dstM] <= W_valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_icode <= I_NOP;
            E_ifun  <= '0;
            E_stat  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_valC  <= '0;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
        end else if (E_bubble) begin
            E_icode <= I_NOP;
            E_ifun  <= '0;
            E_stat  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_valC  <= '0;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
        end else if (!E_stall) begin
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_stat  <= D_stat;
            E_valA  <= valA;
            E_valB  <= valB;
            E_valC  <= D_valC;
            E_srcA  <= srcA;
            E_srcB  <= srcB;
            E_dstE  <= dstE;
            E_dstM  <= dstM;
        end
    end

endmodule
